kp_row_scan_ctrl: RTL and testbench
===================================

Name: kp_row_scan_ctrl

Overview:
Parametrised successor of the DoG keypoint detect/filter controller. It sequences row fetches from the blur/DoG SRAMs, drives the line-buffer shift and captures the per-scale candidate masks (detector AND filter, computed externally). It then serialises every set bit into (scale, row, col) records written to keypoint SRAM through a ready/valid handshake. Generalised in image size, scale count and SRAM read latency; adds per-scale overflow protection and back-pressure.

Parameters:
IMG_W, 640, pixels per row; COL_W = clog2(IMG_W)
IMG_H, 480, rows per image; ROW_W = clog2(IMG_H)
N_SCALE, 2, detector scales (mask lanes)
RD_LAT, 1, SRAM read latency in cycles (>=1)
KP_DEPTH, 2048, keypoint SRAM entries per scale; KP_AW = clog2(KP_DEPTH)
MAX_PER_ROW, 64, per-row per-scale cap (used only with KP_ROWCAP_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin frame scan; sampled in IDLE only
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at end of frame
rd_en  out  1  SRAM read strobe
row_addr  out  ROW_W  SRAM row address
buffer_we  out  1  line-buffer shift strobe
kp_mask  in  N_SCALE*IMG_W  candidate masks; lane s = bits [s*IMG_W +: IMG_W], bit c = column c
kp_we  out  1  record valid
kp_ready  in  1  SRAM/arbiter accepts record
kp_scale  out  clog2(N_SCALE) (min 1)  scale of record
kp_addr  out  KP_AW  per-scale write address
kp_din  out  ROW_W+COL_W  {row, col}
kp_overflow  out  N_SCALE  sticky per-scale overflow

Behaviour:
- Async reset: state IDLE, all outputs 0, row counter, scan state and per-scale address counters cleared. Reset mid-frame aborts with no done pulse.
- States: IDLE, FETCH, WAIT, CAPTURE, SCAN, SHIFT, FIN.
- IDLE: on start go to FETCH with row=0; clear kp_overflow and the address counters. start in any other state is ignored.
- FETCH (1 cycle): rd_en=1, row_addr=row. Then WAIT.
- WAIT: exactly RD_LAT cycles. Then CAPTURE if row>=2, else SHIFT.
- CAPTURE (1 cycle): latch kp_mask; force columns 0 and IMG_W-1 to zero in every lane. Centre row = row-1. Then SCAN with scale index 0.
- SCAN: each cycle, if the current lane has set bits, present the lowest set column (kp_we=1, kp_din={row-1, col}, kp_scale, kp_addr=addr[s]).
  - kp_we/kp_din/kp_scale/kp_addr stay stable until kp_ready. On kp_we&&kp_ready: clear that bit, addr[s]++.
  - If the lane is empty, advance the scale index; this costs one cycle and there is no record.
  - After the last lane is empty, go to SHIFT.
- Overflow: if addr[s]==KP_DEPTH-1 and a write is accepted, the address saturates and kp_overflow[s] sets. Later candidates of scale s are cleared one per cycle with kp_we=0 and no write.
- SHIFT (1 cycle): buffer_we=1; row++. If row was IMG_H-1 go to FIN, else FETCH.
- FIN (1 cycle): done=1, then IDLE. kp_overflow and the address counters hold until the next start.
- Outputs are registered; kp_we never asserts outside SCAN.

Optional Feature:
KP_ROWCAP_EN
- Defined: a per-row per-scale counter, reset in CAPTURE, limits each lane to MAX_PER_ROW accepted records per row. Remaining bits in that lane are discarded by advancing the lane immediately; kp_overflow is unaffected.
- Undefined: no per-row limit; MAX_PER_ROW is unused.

Decomposition:
- Package kp_scan_pkg holds:
  - the state enumeration;
  - the ROW_W/COL_W/KP_AW derivation functions (clog2);
  - the record width constant ROW_W+COL_W.
- One sub-module, kp_lsb_enc (WIDTH param): lowest-set-bit index plus any-set flag over one lane. It is instantiated once and muxed by the scale index.

Test Plan:
(Bench uses IMG_W=16, IMG_H=8, N_SCALE=2, RD_LAT=2, KP_DEPTH=4.)
- All-zero masks, start pulse -> 8 FETCH/SHIFT pairs, no kp_we, done pulse exactly once, busy low the cycle after FIN.
- Lane0 bits {3,7}, lane1 bit 5 on the capture of row 4, kp_ready=1 -> records (s0,row3,col3,addr0), (s0,row3,col7,addr1), (s1,row3,col5,addr0) in that order.
- Bits at columns 0 and 15 set in every row -> no records (border masked); rows 0 and 1 never enter SCAN.
- kp_ready low for 5 cycles during a record -> kp_we, kp_din and kp_addr stay constant; one write per accepted handshake.
- Lane0 with 6 candidates across the frame -> addr0 saturates at 3, kp_overflow[0]=1 after the 4th write, 2 dropped; lane1 unaffected.
- rst_n asserted mid-SCAN -> all outputs 0 immediately; a new start scans from row 0 with addresses 0.

Source files
------------

// File: rtl/kp_scan_pkg.sv
// -----------------------------------------------------------------------------
// kp_scan_pkg
// Shared definitions for the DoG keypoint row-scan controller:
//   - kp_state_e : controller state enumeration
//   - kp_clog2   : ceil(log2(n)) clamped to a minimum of 1 bit
//   - kp_col_w / kp_row_w / kp_aw / kp_rec_w : derived field widths
//   - KP_REC_W_DEFAULT : {row, col} record width for the default 640x480 image
// -----------------------------------------------------------------------------
package kp_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SCAN    = 3'd4,
    ST_SHIFT   = 3'd5,
    ST_FIN     = 3'd6
  } kp_state_e;

  // ceil(log2(n)), never below 1 so single-entry fields still get a bit.
  function automatic int kp_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int kp_col_w(input int img_w);
    return kp_clog2(img_w);
  endfunction

  function automatic int kp_row_w(input int img_h);
    return kp_clog2(img_h);
  endfunction

  function automatic int kp_aw(input int depth);
    return kp_clog2(depth);
  endfunction

  // Keypoint record payload is {row, col}.
  function automatic int kp_rec_w(input int img_w, input int img_h);
    return kp_row_w(img_h) + kp_col_w(img_w);
  endfunction

  localparam int KP_REC_W_DEFAULT = kp_rec_w(640, 480);

endpackage

// File: rtl/kp_lsb_enc.sv
// -----------------------------------------------------------------------------
// kp_lsb_enc
// Lowest-set-bit encoder over one candidate lane.
// Ports:
//   i_vec [WIDTH-1:0]       : lane bits, bit c = column c
//   o_idx [clog2(WIDTH)-1:0]: index of the lowest set bit (0 when none set)
//   o_any                   : at least one bit of i_vec is set
// -----------------------------------------------------------------------------
module kp_lsb_enc
  import kp_scan_pkg::*;
#(
  parameter int WIDTH = 640
) (
  input  logic [WIDTH-1:0]           i_vec,
  output logic [kp_clog2(WIDTH)-1:0] o_idx,
  output logic                       o_any
);

  localparam int IW = kp_clog2(WIDTH);

  // Walk from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    o_any = |i_vec;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IW'(i);
    end
  end

endmodule

// File: rtl/kp_row_scan_ctrl.sv
// -----------------------------------------------------------------------------
// kp_row_scan_ctrl
// Sequences row fetches from the blur/DoG SRAMs, shifts the line buffer,
// captures the per-scale candidate masks and serialises every set bit into
// (scale, row, col) records for keypoint SRAM over a ready/valid handshake.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : begin a frame (only honoured in IDLE)
//   busy, done     : high outside IDLE / one-cycle end-of-frame pulse
//   rd_en,row_addr : SRAM read strobe and row address
//   buffer_we      : line-buffer shift strobe
//   kp_mask        : N_SCALE candidate lanes of IMG_W bits each
//   kp_we/kp_ready : record valid / record accepted
//   kp_scale,kp_addr,kp_din : record scale, per-scale address, {row, col}
//   kp_overflow    : sticky per-scale address overflow
//
// Build option: define KP_ROWCAP_EN to cap accepted records per row per scale
// at MAX_PER_ROW; without it MAX_PER_ROW has no effect.
// -----------------------------------------------------------------------------
module kp_row_scan_ctrl
  import kp_scan_pkg::*;
#(
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int N_SCALE     = 2,
  parameter int RD_LAT      = 1,
  parameter int KP_DEPTH    = 2048,
  parameter int MAX_PER_ROW = 64
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   rd_en,
  output logic [kp_row_w(IMG_H)-1:0]             row_addr,
  output logic                                   buffer_we,
  input  logic [N_SCALE*IMG_W-1:0]               kp_mask,
  output logic                                   kp_we,
  input  logic                                   kp_ready,
  output logic [kp_clog2(N_SCALE)-1:0]           kp_scale,
  output logic [kp_aw(KP_DEPTH)-1:0]             kp_addr,
  output logic [kp_rec_w(IMG_W, IMG_H)-1:0]      kp_din,
  output logic [N_SCALE-1:0]                     kp_overflow
);

  localparam int COL_W = kp_col_w(IMG_W);
  localparam int ROW_W = kp_row_w(IMG_H);
  localparam int KP_AW = kp_aw(KP_DEPTH);
  localparam int SC_W  = kp_clog2(N_SCALE);
  localparam int WT_W  = kp_clog2(RD_LAT + 1);

  // Border columns can never be keypoints (no full neighbourhood).
  localparam logic [IMG_W-1:0] BORDER_KEEP = {1'b0, {(IMG_W-2){1'b1}}, 1'b0};

  kp_state_e                      r_state, w_state_nx;
  logic [ROW_W-1:0]               r_row, w_row_nx;
  logic [WT_W-1:0]                r_wait, w_wait_nx;
  logic [N_SCALE-1:0][IMG_W-1:0]  r_mask, w_mask_nx;
  logic [SC_W-1:0]                r_sidx, w_sidx_nx;
  logic [N_SCALE-1:0][KP_AW-1:0]  r_addr, w_addr_nx;
  logic [N_SCALE-1:0]             r_ovf, w_ovf_nx;
  logic [N_SCALE-1:0][IMG_W-1:0]  w_cand;
  logic [ROW_W-1:0]               w_crow;
  logic [COL_W-1:0]               w_col;
  logic                           w_any;
  logic                           w_capped;

  // Registered view of the encoder: r_hit = current lane still has a usable
  // candidate, r_col = its column.
  logic                           r_hit;
  logic [COL_W-1:0]               r_col;

  logic                           r_busy, r_done, r_rd_en, r_buffer_we;
  logic [ROW_W-1:0]               r_row_addr;
  logic                           r_kp_we;
  logic [SC_W-1:0]                r_kp_scale;
  logic [KP_AW-1:0]               r_kp_addr;
  logic [ROW_W+COL_W-1:0]         r_kp_din;

  genvar gi;
  generate
    for (gi = 0; gi < N_SCALE; gi++) begin : g_lane
      assign w_cand[gi] = kp_mask[gi*IMG_W +: IMG_W] & BORDER_KEEP;
    end
  endgenerate

  assign w_crow = r_row - ROW_W'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nx = r_state;
    w_row_nx   = r_row;
    w_wait_nx  = r_wait;
    w_mask_nx  = r_mask;
    w_sidx_nx  = r_sidx;
    w_addr_nx  = r_addr;
    w_ovf_nx   = r_ovf;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nx = ST_FETCH;
          w_row_nx   = '0;
          w_addr_nx  = '0;
          w_ovf_nx   = '0;
        end
      end
      ST_FETCH: begin
        w_state_nx = ST_WAIT;
        w_wait_nx  = '0;
      end
      ST_WAIT: begin
        if (r_wait == WT_W'(RD_LAT - 1)) begin
          // Detection needs three fetched rows; earlier rows only fill the buffer.
          w_state_nx = (r_row >= ROW_W'(2)) ? ST_CAPTURE : ST_SHIFT;
        end else begin
          w_wait_nx = r_wait + WT_W'(1);
        end
      end
      ST_CAPTURE: begin
        w_mask_nx  = w_cand;
        w_sidx_nx  = '0;
        w_state_nx = ST_SCAN;
      end
      ST_SCAN: begin
        if (r_hit) begin
          if (r_kp_we) begin
            if (kp_ready) begin
              w_mask_nx[r_sidx][r_col] = 1'b0;
              if (r_addr[r_sidx] == KP_AW'(KP_DEPTH - 1)) begin
                w_ovf_nx[r_sidx] = 1'b1;
              end else begin
                w_addr_nx[r_sidx] = r_addr[r_sidx] + KP_AW'(1);
              end
            end
          end else begin
            // Lane has overflowed: discard one candidate per cycle, no write.
            w_mask_nx[r_sidx][r_col] = 1'b0;
          end
        end else if (r_sidx == SC_W'(N_SCALE - 1)) begin
          w_state_nx = ST_SHIFT;
        end else begin
          w_sidx_nx = r_sidx + SC_W'(1);
        end
      end
      ST_SHIFT: begin
        w_row_nx   = r_row + ROW_W'(1);
        w_state_nx = (r_row == ROW_W'(IMG_H - 1)) ? ST_FIN : ST_FETCH;
      end
      ST_FIN: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // The encoder looks at next cycle's lane so the record it finds can be
  // registered and presented without a bubble after each accepted write.
  kp_lsb_enc #(
    .WIDTH (IMG_W)
  ) u_enc (
    .i_vec (w_mask_nx[w_sidx_nx]),
    .o_idx (w_col),
    .o_any (w_any)
  );

`ifdef KP_ROWCAP_EN
  localparam int CNT_W = kp_clog2(MAX_PER_ROW + 1);

  logic [N_SCALE-1:0][CNT_W-1:0] r_rowcnt, w_rowcnt_nx;
  logic                          w_acc;

  assign w_acc = (r_state == ST_SCAN) && r_hit && r_kp_we && kp_ready;

  always_comb begin
    w_rowcnt_nx = r_rowcnt;
    if (r_state == ST_CAPTURE) begin
      w_rowcnt_nx = '0;
    end else if (w_acc) begin
      w_rowcnt_nx[r_sidx] = r_rowcnt[r_sidx] + CNT_W'(1);
    end
  end

  // A capped lane looks empty, so the scan moves on to the next lane.
  assign w_capped = (w_rowcnt_nx[w_sidx_nx] >= CNT_W'(MAX_PER_ROW));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rowcnt <= '0;
    end else begin
      r_rowcnt <= w_rowcnt_nx;
    end
  end
`else
  // No per-row cap in this build; MAX_PER_ROW only matters with the cap.
  assign w_capped = (MAX_PER_ROW < 0);
`endif

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_row       <= '0;
      r_wait      <= '0;
      r_mask      <= '0;
      r_sidx      <= '0;
      r_addr      <= '0;
      r_ovf       <= '0;
      r_hit       <= 1'b0;
      r_col       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_buffer_we <= 1'b0;
      r_row_addr  <= '0;
      r_kp_we     <= 1'b0;
      r_kp_scale  <= '0;
      r_kp_addr   <= '0;
      r_kp_din    <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_row       <= w_row_nx;
      r_wait      <= w_wait_nx;
      r_mask      <= w_mask_nx;
      r_sidx      <= w_sidx_nx;
      r_addr      <= w_addr_nx;
      r_ovf       <= w_ovf_nx;
      r_hit       <= (w_state_nx == ST_SCAN) && w_any && !w_capped;
      r_col       <= w_col;
      r_busy      <= (w_state_nx != ST_IDLE);
      r_done      <= (w_state_nx == ST_FIN);
      r_rd_en     <= (w_state_nx == ST_FETCH);
      r_buffer_we <= (w_state_nx == ST_SHIFT);
      r_row_addr  <= w_row_nx;
      r_kp_we     <= (w_state_nx == ST_SCAN) && w_any && !w_capped
                     && !w_ovf_nx[w_sidx_nx];
      r_kp_scale  <= w_sidx_nx;
      r_kp_addr   <= w_addr_nx[w_sidx_nx];
      r_kp_din    <= {w_crow, w_col};
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign rd_en       = r_rd_en;
  assign row_addr    = r_row_addr;
  assign buffer_we   = r_buffer_we;
  assign kp_we       = r_kp_we;
  assign kp_scale    = r_kp_scale;
  assign kp_addr     = r_kp_addr;
  assign kp_din      = r_kp_din;
  assign kp_overflow = r_ovf;

endmodule

// File: tb/tb_kp_row_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_kp_row_scan_ctrl
// Scoreboard bench: each frame's expected records are queued before start,
// and a negedge monitor compares every presented record against the queue
// head, popping it when the handshake completes.
// -----------------------------------------------------------------------------
module tb_kp_row_scan_ctrl;

  localparam int IMG_W    = 16;
  localparam int IMG_H    = 8;
  localparam int N_SCALE  = 2;
  localparam int RD_LAT   = 2;
  localparam int KP_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, rd_en, buffer_we;
  logic [2:0]  row_addr;
  logic [31:0] kp_mask;
  logic        kp_we, kp_ready;
  logic [0:0]  kp_scale;
  logic [1:0]  kp_addr;
  logic [6:0]  kp_din;
  logic [1:0]  kp_overflow;

  logic [31:0] tbl [0:IMG_H-1];   // {lane1, lane0} per fetched row
  logic [9:0]  exp_q [$];          // {scale, addr, row, col}

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt = 0, rd_cnt = 0, sh_cnt = 0, done_cnt = 0;
  bit prev_hold = 1'b0;

  always #5 clk = ~clk;

  // The masks follow the row currently addressed, like an SRAM-fed pipeline.
  assign kp_mask = tbl[row_addr];

  kp_row_scan_ctrl #(
    .IMG_W       (IMG_W),
    .IMG_H       (IMG_H),
    .N_SCALE     (N_SCALE),
    .RD_LAT      (RD_LAT),
    .KP_DEPTH    (KP_DEPTH),
    .MAX_PER_ROW (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .rd_en       (rd_en),
    .row_addr    (row_addr),
    .buffer_we   (buffer_we),
    .kp_mask     (kp_mask),
    .kp_we       (kp_we),
    .kp_ready    (kp_ready),
    .kp_scale    (kp_scale),
    .kp_addr     (kp_addr),
    .kp_din      (kp_din),
    .kp_overflow (kp_overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [9:0] mk_rec(input int s, input int a, input int r, input int c);
    logic [0:0] sb;
    logic [1:0] ab;
    logic [2:0] rb;
    logic [3:0] cb;
    sb = s[0:0];
    ab = a[1:0];
    rb = r[2:0];
    cb = c[3:0];
    return {sb, ab, rb, cb};
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) chk("hold_we", {31'd0, kp_we}, 32'd1);
      if (kp_we) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL unexpected_rec: got s%0d a%0d din %0h, expected no record",
                   kp_scale, kp_addr, kp_din);
        end else begin
          chk("rec", {22'd0, kp_scale, kp_addr, kp_din}, {22'd0, exp_q[0]});
          if (kp_ready) void'(exp_q.pop_front());
        end
        if (kp_ready) wr_cnt++;
      end
      if (done)      done_cnt++;
      if (rd_en)     rd_cnt++;
      if (buffer_we) sh_cnt++;
      prev_hold = kp_we && !kp_ready;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic clear_tbl();
    for (int r = 0; r < IMG_H; r++) tbl[r] = 32'd0;
  endtask

  task automatic start_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      @(negedge clk);
      chk("busy_after_fin", {31'd0, busy}, 32'd0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_we();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (kp_we) seen = 1'b1;
    end
    chk("we_seen", {31'd0, seen}, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int b_rd, b_sh, b_done, b_wr;
    rst_n    = 1'b0;
    start    = 1'b0;
    kp_ready = 1'b1;
    clear_tbl();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_done",  {31'd0, done},  32'd0);
    chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
    chk("rst_kp_we", {31'd0, kp_we}, 32'd0);
    chk("rst_ovf",   {30'd0, kp_overflow}, 32'd0);
    rst_n = 1'b1;

    // All-zero masks: 8 fetch/shift pairs, one done, no records.
    b_rd = rd_cnt; b_sh = sh_cnt; b_done = done_cnt; b_wr = wr_cnt;
    start_frame();
    wait_done();
    chk("zero_fetches", rd_cnt - b_rd, 8);
    chk("zero_shifts",  sh_cnt - b_sh, 8);
    chk("zero_done",    done_cnt - b_done, 1);
    chk("zero_writes",  wr_cnt - b_wr, 0);

    // Lane0 {3,7}, lane1 {5} captured with row 4 -> centre row 3.
    clear_tbl();
    tbl[4] = 32'h0020_0088;
    exp_q.push_back(mk_rec(0, 0, 3, 3));
    exp_q.push_back(mk_rec(0, 1, 3, 7));
    exp_q.push_back(mk_rec(1, 0, 3, 5));
    b_wr = wr_cnt;
    start_frame();
    wait_done();
    chk("basic_writes", wr_cnt - b_wr, 3);
    chk("basic_q_empty", exp_q.size(), 0);

    // Border columns set everywhere: all masked.
    for (int r = 0; r < IMG_H; r++) tbl[r] = 32'h8001_8001;
    b_wr = wr_cnt;
    start_frame();
    wait_done();
    chk("border_writes", wr_cnt - b_wr, 0);

    // Back-pressure: kp_ready low for 5 cycles while a record waits.
    clear_tbl();
    tbl[4] = 32'h0000_0200;
    exp_q.push_back(mk_rec(0, 0, 3, 9));
    kp_ready = 1'b0;
    b_wr = wr_cnt;
    start_frame();
    wait_we();
    repeat (5) @(posedge clk);
    #1 kp_ready = 1'b1;
    wait_done();
    chk("hold_writes", wr_cnt - b_wr, 1);
    chk("hold_q_empty", exp_q.size(), 0);

    // Overflow: six lane0 candidates, depth 4.
    clear_tbl();
    tbl[3] = 32'h0000_0014;          // row 2: cols 2,4
    tbl[5] = 32'h0100_0442;          // row 4: lane0 cols 1,6,10; lane1 col 8
    tbl[7] = 32'h0000_4000;          // row 6: col 14 (dropped)
    exp_q.push_back(mk_rec(0, 0, 2, 2));
    exp_q.push_back(mk_rec(0, 1, 2, 4));
    exp_q.push_back(mk_rec(0, 2, 4, 1));
    exp_q.push_back(mk_rec(0, 3, 4, 6));
    exp_q.push_back(mk_rec(1, 0, 4, 8));
    b_wr = wr_cnt;
    start_frame();
    wait_done();
    chk("ovf_writes", wr_cnt - b_wr, 5);
    chk("ovf_flag", {30'd0, kp_overflow}, 32'd1);
    chk("ovf_q_empty", exp_q.size(), 0);

    // Overflow holds in IDLE and clears on the next start.
    clear_tbl();
    chk("ovf_hold_idle", {30'd0, kp_overflow}, 32'd1);
    start_frame();
    chk("ovf_cleared", {30'd0, kp_overflow}, 32'd0);
    wait_done();

    // Reset mid-SCAN while a record is stalled.
    tbl[4] = 32'h0000_7FFE;
    exp_q.push_back(mk_rec(0, 0, 3, 1));
    kp_ready = 1'b0;
    start_frame();
    wait_we();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_kp_we",    {31'd0, kp_we},    32'd0);
    chk("mrst_busy",     {31'd0, busy},     32'd0);
    chk("mrst_rd_en",    {31'd0, rd_en},    32'd0);
    chk("mrst_row_addr", {29'd0, row_addr}, 32'd0);
    chk("mrst_kp_din",   {25'd0, kp_din},   32'd0);
    chk("mrst_kp_addr",  {30'd0, kp_addr},  32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    kp_ready = 1'b1;
    clear_tbl();
    tbl[4] = 32'h0000_0020;
    exp_q.push_back(mk_rec(0, 0, 3, 5));
    b_wr = wr_cnt;
    b_done = done_cnt;
    start_frame();
    chk("restart_rd_en", {31'd0, rd_en}, 32'd1);
    chk("restart_row0",  {29'd0, row_addr}, 32'd0);
    wait_done();
    chk("restart_writes", wr_cnt - b_wr, 1);
    chk("restart_done",   done_cnt - b_done, 1);
    chk("final_q_empty",  exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
